// File: rtl/keccak_msg_feed.sv
// keccak_msg_feed: pads a 64-bit message word stream (pad10*1 with a domain byte)
// and feeds it one rate block at a time into keccak_round. After each block it
// pulses run and waits for complete before starting the next block.
// Ports:
//   clk_i, rst_ni                          clock, async active-low reset
//   msg_valid_i/msg_data_i/msg_strb_i/
//   msg_last_i/msg_ready_o                 message word stream (byte 0 in [7:0])
//   keccak_valid_o/addr_o/data_o           feed word to keccak_round
//   keccak_ready_i                         keccak_round idle
//   keccak_run_o                           one-cycle permutation start
//   keccak_complete_i                      permutation finished
//   absorbed_o                             one-cycle pulse, whole padded message absorbed
//   err_o                                  sticky protocol error
module keccak_msg_feed #(
  parameter int unsigned Width      = 1600,
  parameter int unsigned DInWidth   = 64,
  parameter int unsigned RateWords  = 17,
  parameter logic [7:0]  DomainByte = 8'h06,
  localparam int unsigned DInAddr   = $clog2(Width / DInWidth)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               msg_valid_i,
  input  logic [63:0]        msg_data_i,
  input  logic [7:0]         msg_strb_i,
  input  logic               msg_last_i,
  output logic               msg_ready_o,
  output logic               keccak_valid_o,
  output logic [DInAddr-1:0] keccak_addr_o,
  output logic [63:0]        keccak_data_o,
  input  logic               keccak_ready_i,
  output logic               keccak_run_o,
  input  logic               keccak_complete_i,
  output logic               absorbed_o,
  output logic               err_o
);

  typedef enum logic [2:0] {
    StAbsorb = 3'd0,
    StPad    = 3'd1,
    StRun    = 3'd2,
    StWait   = 3'd3,
    StError  = 3'd4
  } state_e;

  localparam logic [DInAddr-1:0] LastAddr = DInAddr'(RateWords - 1);

  state_e             state_q, state_d;
  logic [DInAddr-1:0] addr_q, addr_d;
  logic               pad_pend_q, pad_pend_d;
  logic               final_q, final_d;
  logic               absorbed_q, absorbed_d;

  logic        last_addr;
  logic [3:0]  k;
  logic        pad_here;
  logic        strb_bad;
  logic        accept;
  logic [63:0] absorb_word;
  logic [63:0] pad_word;

  assign last_addr = (addr_q == LastAddr);
  assign accept    = msg_valid_i & keccak_ready_i;

  // A last word may carry 0..8 bytes packed from the LSB; any other word must be full.
  assign strb_bad = msg_last_i ? ((msg_strb_i & (msg_strb_i + 8'd1)) != 8'd0)
                               : (msg_strb_i != 8'hFF);

  // Message word: masked data, domain byte right after the last message byte,
  // and the closing 0x80 bit when padding ends in the final rate word.
  always_comb begin
    k = '0;
    for (int i = 0; i < 8; i++) k = k + 4'(msg_strb_i[i]);
    pad_here    = msg_last_i & ~k[3];
    absorb_word = '0;
    for (int i = 0; i < 8; i++) begin
      if (msg_strb_i[i]) absorb_word[8*i +: 8] = msg_data_i[8*i +: 8];
    end
    if (pad_here) begin
      absorb_word[{k[2:0], 3'b000} +: 8] = DomainByte;
      if (last_addr) absorb_word[63:56] = absorb_word[63:56] | 8'h80;
    end
  end

  // Padding-only word: domain byte if still owed, closing bit at the end of the block.
  always_comb begin
    pad_word = '0;
    if (pad_pend_q) pad_word[7:0] = DomainByte;
    if (last_addr)  pad_word[63:56] = pad_word[63:56] | 8'h80;
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StAbsorb;
      addr_q     <= '0;
      pad_pend_q <= 1'b0;
      final_q    <= 1'b0;
      absorbed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pad_pend_q <= pad_pend_d;
      final_q    <= final_d;
      absorbed_q <= absorbed_d;
    end
  end

  assign absorbed_o = absorbed_q;
  assign err_o      = (state_q == StError);

  // Next-state and feed/handshake outputs.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    pad_pend_d     = pad_pend_q;
    final_d        = final_q;
    absorbed_d     = 1'b0;
    msg_ready_o    = 1'b0;
    keccak_valid_o = 1'b0;
    keccak_addr_o  = '0;
    keccak_data_o  = '0;
    keccak_run_o   = 1'b0;

    case (state_q)
      StAbsorb: begin
        msg_ready_o   = keccak_ready_i;
        keccak_addr_o = addr_q;
        keccak_data_o = absorb_word;
        if (accept) begin
          if (strb_bad) begin
            state_d = StError;
          end else begin
            keccak_valid_o = 1'b1;
            addr_d         = addr_q + 1'b1;
            if (msg_last_i) begin
              final_d = 1'b1;
              if (k[3]) pad_pend_d = 1'b1;
            end
            if (last_addr) begin
              state_d = StRun;
              addr_d  = '0;
            end else if (msg_last_i) begin
              // Padding (including a still-owed domain byte) finishes the block.
              state_d = StPad;
            end
          end
        end
      end

      StPad: begin
        keccak_addr_o = addr_q;
        keccak_data_o = pad_word;
        if (keccak_ready_i) begin
          keccak_valid_o = 1'b1;
          pad_pend_d     = 1'b0;
          addr_d         = addr_q + 1'b1;
          if (last_addr) begin
            state_d = StRun;
            addr_d  = '0;
          end
        end
      end

      StRun: begin
        if (keccak_ready_i) begin
          keccak_run_o = 1'b1;
          state_d      = StWait;
        end
      end

      StWait: begin
        if (keccak_complete_i) begin
          addr_d = '0;
          if (pad_pend_q) begin
            state_d = StPad;
          end else begin
            state_d    = StAbsorb;
            absorbed_d = final_q;
            final_d    = 1'b0;
          end
        end
      end

      StError: begin
      end

      default: state_d = StError;
    endcase
  end

endmodule

// File: tb/tb_keccak_msg_feed.sv
// Directed bench for keccak_msg_feed with a small keccak_round responder model.
module tb_keccak_msg_feed;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        msg_valid_i = 1'b0;
  logic [63:0] msg_data_i = '0;
  logic [7:0]  msg_strb_i = '0;
  logic        msg_last_i = 1'b0;
  logic        msg_ready_o;
  logic        keccak_valid_o;
  logic [4:0]  keccak_addr_o;
  logic [63:0] keccak_data_o;
  logic        keccak_ready_i;
  logic        keccak_run_o;
  logic        keccak_complete_i;
  logic        absorbed_o;
  logic        err_o;

  logic        stall = 1'b0;
  logic [2:0]  kbusy;

  int errors = 0;
  int checks = 0;
  int nwords, run_cnt, absorbed_cnt, viol;
  logic [63:0] blk   [17];
  logic [63:0] hist0 [17];
  logic [63:0] hist1 [17];

  keccak_msg_feed dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .msg_valid_i       (msg_valid_i),
    .msg_data_i        (msg_data_i),
    .msg_strb_i        (msg_strb_i),
    .msg_last_i        (msg_last_i),
    .msg_ready_o       (msg_ready_o),
    .keccak_valid_o    (keccak_valid_o),
    .keccak_addr_o     (keccak_addr_o),
    .keccak_data_o     (keccak_data_o),
    .keccak_ready_i    (keccak_ready_i),
    .keccak_run_o      (keccak_run_o),
    .keccak_complete_i (keccak_complete_i),
    .absorbed_o        (absorbed_o),
    .err_o             (err_o)
  );

  always #5 clk_i = ~clk_i;

  // keccak_round stand-in: busy for four cycles after run, complete on the last.
  assign keccak_ready_i    = (kbusy == 3'd0) && !stall;
  assign keccak_complete_i = (kbusy == 3'd1);

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      kbusy        <= 3'd0;
      nwords       = 0;
      run_cnt      = 0;
      absorbed_cnt = 0;
      viol         = 0;
      blk   = '{default: '0};
      hist0 = '{default: '0};
      hist1 = '{default: '0};
    end else begin
      if (keccak_valid_o && (keccak_run_o || !keccak_ready_i)) viol++;
      if (keccak_run_o && !keccak_ready_i) viol++;
      if (keccak_valid_o && keccak_ready_i) begin
        if (keccak_addr_o < 5'd17) blk[keccak_addr_o] = keccak_data_o;
        nwords++;
      end
      if (keccak_run_o) begin
        if (run_cnt == 0) hist0 = blk;
        if (run_cnt == 1) hist1 = blk;
        run_cnt++;
        blk = '{default: '0};
        kbusy <= 3'd4;
      end else if (kbusy != 3'd0) begin
        kbusy <= kbusy - 3'd1;
      end
      if (absorbed_o) absorbed_cnt++;
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    msg_valid_i = 1'b0;
    msg_last_i = 1'b0;
    msg_strb_i = '0;
    msg_data_i = '0;
    stall = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  // Present one word and hold it until the DUT accepts it (bounded).
  task automatic send(input logic [63:0] d, input logic [7:0] s, input logic l);
    bit ok = 0;
    @(negedge clk_i);
    msg_valid_i = 1'b1;
    msg_data_i = d;
    msg_strb_i = s;
    msg_last_i = l;
    for (int n = 0; n < 200 && !ok; n++) begin
      #1;
      if (msg_ready_o) ok = 1;
      @(negedge clk_i);
    end
    msg_valid_i = 1'b0;
    msg_last_i = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: word %h never accepted", d);
    end
  endtask

  task automatic wait_absorbed(input int target);
    for (int n = 0; n < 500 && absorbed_cnt < target; n++) @(negedge clk_i);
    repeat (3) @(negedge clk_i);
    checks++;
    if (absorbed_cnt !== target) begin
      errors++;
      $display("FAIL absorbed_count: got %0d expected %0d", absorbed_cnt, target);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({keccak_valid_o, keccak_run_o, absorbed_o, err_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {keccak_valid_o, keccak_run_o, absorbed_o, err_o});
    end
    checks++;
    if (keccak_addr_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_addr: got %0d expected 0", keccak_addr_o);
    end
    do_reset();
    checks++;
    if ({err_o, keccak_run_o, msg_ready_o} !== 3'b001) begin
      errors++;
      $display("FAIL reset_release: got %b expected 001", {err_o, keccak_run_o, msg_ready_o});
    end
  endtask

  task automatic test_empty();
    bit zero_ok = 1;
    do_reset();
    send(64'h0, 8'h00, 1'b1);
    wait_absorbed(1);
    for (int i = 1; i < 16; i++) if (hist0[i] !== 64'h0) zero_ok = 0;
    checks++;
    if (hist0[0] !== 64'h0000_0000_0000_0006) begin
      errors++;
      $display("FAIL empty_addr0: got %h expected 0000000000000006", hist0[0]);
    end
    checks++;
    if (!zero_ok) begin
      errors++;
      $display("FAIL empty_mid_zero: got nonzero words expected all zero");
    end
    checks++;
    if (hist0[16] !== 64'h8000_0000_0000_0000) begin
      errors++;
      $display("FAIL empty_addr16: got %h expected 8000000000000000", hist0[16]);
    end
    checks++;
    if (run_cnt !== 1 || nwords !== 17 || viol !== 0) begin
      errors++;
      $display("FAIL empty_counts: got runs=%0d words=%0d viol=%0d expected 1 17 0",
               run_cnt, nwords, viol);
    end
  endtask

  task automatic test_abc();
    do_reset();
    send(64'h0000_0000_0063_6261, 8'h07, 1'b1);
    wait_absorbed(1);
    checks++;
    if (hist0[0] !== 64'h0000_0000_0663_6261) begin
      errors++;
      $display("FAIL abc_addr0: got %h expected 0000000006636261", hist0[0]);
    end
    checks++;
    if (hist0[1] !== 64'h0 || hist0[16] !== 64'h8000_0000_0000_0000) begin
      errors++;
      $display("FAIL abc_pad: got %h/%h expected 0/8000000000000000", hist0[1], hist0[16]);
    end
  endtask

  task automatic test_full_block();
    bit zero_ok = 1;
    do_reset();
    for (int i = 0; i < 17; i++) send(64'h1111_0000_0000_0000 + 64'(i), 8'hFF, i == 16);
    wait_absorbed(1);
    for (int i = 1; i < 16; i++) if (hist1[i] !== 64'h0) zero_ok = 0;
    checks++;
    if (hist0[0] !== 64'h1111_0000_0000_0000 || hist0[15] !== 64'h1111_0000_0000_000F) begin
      errors++;
      $display("FAIL full_msg_words: got %h/%h expected 1111000000000000/111100000000000f",
               hist0[0], hist0[15]);
    end
    checks++;
    if (run_cnt !== 2) begin
      errors++;
      $display("FAIL full_runs: got %0d expected 2", run_cnt);
    end
    checks++;
    if (hist1[0] !== 64'h6 || hist1[16] !== 64'h8000_0000_0000_0000 || !zero_ok) begin
      errors++;
      $display("FAIL full_pad_block: got %h/%h zero=%0d expected 6/8000000000000000 1",
               hist1[0], hist1[16], zero_ok);
    end
  endtask

  task automatic test_byte7_pad();
    do_reset();
    for (int i = 0; i < 16; i++) send(64'hA5A5_0000_0000_0000 + 64'(i), 8'hFF, 1'b0);
    send(64'hFFEE_DDCC_BBAA_9988, 8'h7F, 1'b1);
    wait_absorbed(1);
    checks++;
    if (hist0[16] !== 64'h86EE_DDCC_BBAA_9988) begin
      errors++;
      $display("FAIL byte7_addr16: got %h expected 86eeddccbbaa9988", hist0[16]);
    end
    checks++;
    if (run_cnt !== 1) begin
      errors++;
      $display("FAIL byte7_runs: got %0d expected 1", run_cnt);
    end
  endtask

  task automatic test_stall();
    do_reset();
    send(64'h1, 8'hFF, 1'b0);
    send(64'h2, 8'hFF, 1'b0);
    stall = 1'b1;
    msg_valid_i = 1'b1;
    msg_data_i = 64'h3;
    msg_strb_i = 8'hFF;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if (msg_ready_o !== 1'b0 || keccak_valid_o !== 1'b0 || keccak_addr_o !== 5'd2 || nwords !== 2) begin
      errors++;
      $display("FAIL stall_absorb: got rdy=%b vld=%b addr=%0d words=%0d expected 0 0 2 2",
               msg_ready_o, keccak_valid_o, keccak_addr_o, nwords);
    end
    msg_valid_i = 1'b0;
    stall = 1'b0;
    send(64'h0000_0000_0000_00AB, 8'h01, 1'b1);
    stall = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if (keccak_valid_o !== 1'b0 || keccak_addr_o !== 5'd3 || nwords !== 3) begin
      errors++;
      $display("FAIL stall_pad: got vld=%b addr=%0d words=%0d expected 0 3 3",
               keccak_valid_o, keccak_addr_o, nwords);
    end
    stall = 1'b0;
    wait_absorbed(1);
    checks++;
    if (hist0[2] !== 64'h06AB || hist0[3] !== 64'h0 || hist0[16] !== 64'h8000_0000_0000_0000 || viol !== 0) begin
      errors++;
      $display("FAIL stall_block: got %h/%h/%h viol=%0d expected 6ab/0/8000000000000000 0",
               hist0[2], hist0[3], hist0[16], viol);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(64'h0000_0000_0063_6261, 8'h07, 1'b1);
    wait_absorbed(1);
    send(64'h0, 8'h00, 1'b1);
    wait_absorbed(2);
    checks++;
    if (run_cnt !== 2 || hist1[0] !== 64'h6) begin
      errors++;
      $display("FAIL b2b_second: got runs=%0d addr0=%h expected 2 6", run_cnt, hist1[0]);
    end
  endtask

  task automatic test_error();
    do_reset();
    send(64'h0000_0000_00CC_00AA, 8'h05, 1'b1);
    checks++;
    if (err_o !== 1'b1 || nwords !== 0) begin
      errors++;
      $display("FAIL err_last: got err=%b words=%0d expected 1 0", err_o, nwords);
    end
    msg_valid_i = 1'b1;
    msg_data_i = 64'h1234;
    msg_strb_i = 8'hFF;
    repeat (5) @(negedge clk_i);
    #1;
    checks++;
    if (err_o !== 1'b1 || msg_ready_o !== 1'b0 || keccak_valid_o !== 1'b0 || nwords !== 0 || run_cnt !== 0) begin
      errors++;
      $display("FAIL err_sticky: got err=%b rdy=%b vld=%b words=%0d runs=%0d expected 1 0 0 0 0",
               err_o, msg_ready_o, keccak_valid_o, nwords, run_cnt);
    end
    msg_valid_i = 1'b0;
    do_reset();
    send(64'h5555, 8'h0F, 1'b0);
    checks++;
    if (err_o !== 1'b1 || nwords !== 0) begin
      errors++;
      $display("FAIL err_partial: got err=%b words=%0d expected 1 0", err_o, nwords);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_full_block();
    test_byte7_pad();
    test_stall();
    test_back_to_back();
    test_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
